// File: rtl/fwd_hazard_if.sv
// ID-side decode fields into the forwarding/hazard unit and its EX bypass selects back out.
// master = decode/pipeline side, slave = fwd_hazard_unit.
interface fwd_hazard_if #(
   parameter int RA_W  = 5,
   parameter int DEPTH = 3,
   parameter int CNT_W = 32,
   localparam int SEL_W = $clog2(DEPTH + 1)
);
   logic             id_valid;
   logic [RA_W-1:0]  id_rs1;
   logic [RA_W-1:0]  id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [RA_W-1:0]  id_rd;
   logic             id_rd_we;
   logic             id_is_load;
   logic             flush;
   logic             id_stall;
   logic [SEL_W-1:0] ex_fwd1_sel;
   logic [SEL_W-1:0] ex_fwd2_sel;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_we, id_is_load, flush,
      input  id_stall, ex_fwd1_sel, ex_fwd2_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_we, id_is_load, flush,
      output id_stall, ex_fwd1_sel, ex_fwd2_sel, stall_cnt
   );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Scoreboard forwarding/hazard unit: DEPTH-entry producer history, distance-encoded EX bypass selects
// (registered, 1 cycle after issue), combinational load-use stall to IF/ID, saturating stall counter.
module fwd_hazard_unit #(
   parameter int DEPTH     = 3,
   parameter int LOAD_DIST = 2,
   parameter int RA_W      = 5,
   parameter int CNT_W     = 32,
   localparam int SEL_W    = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic rst,
   fwd_hazard_if.slave bus
);

   logic             h_v  [1:DEPTH];
   logic             h_we [1:DEPTH];
   logic             h_ld [1:DEPTH];
   logic [RA_W-1:0]  h_rd [1:DEPTH];

   logic [SEL_W-1:0] sel1, sel2;
   logic             haz1, haz2;
   logic             stall, issue;
   logic [SEL_W-1:0] fwd1_q, fwd2_q;
   logic [CNT_W-1:0] cnt_q;

   // Scan oldest to youngest so the youngest matching producer overwrites older ones.
   always_comb begin
      sel1 = '0;
      sel2 = '0;
      haz1 = 1'b0;
      haz2 = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (h_v[k] && h_we[k] && bus.id_rs1_used && bus.id_rs1 != '0 && h_rd[k] == bus.id_rs1) begin
            sel1 = SEL_W'(k);
            haz1 = h_ld[k] && (k < LOAD_DIST);
         end
         if (h_v[k] && h_we[k] && bus.id_rs2_used && bus.id_rs2 != '0 && h_rd[k] == bus.id_rs2) begin
            sel2 = SEL_W'(k);
            haz2 = h_ld[k] && (k < LOAD_DIST);
         end
      end
   end

   assign stall = bus.id_valid && !bus.flush && (haz1 || haz2);
   assign issue = bus.id_valid && !stall && !bus.flush;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 1; k <= DEPTH; k++) begin
            h_v[k]  <= 1'b0;
            h_we[k] <= 1'b0;
            h_ld[k] <= 1'b0;
            h_rd[k] <= '0;
         end
         fwd1_q <= '0;
         fwd2_q <= '0;
         cnt_q  <= '0;
      end else begin
         for (int k = DEPTH; k >= 2; k--) begin
            h_v[k]  <= h_v[k-1];
            h_we[k] <= h_we[k-1];
            h_ld[k] <= h_ld[k-1];
            h_rd[k] <= h_rd[k-1];
         end
         // x0 is never a producer, so its we bit is dropped on entry.
         h_v[1]  <= issue;
         h_we[1] <= bus.id_rd_we && (bus.id_rd != '0);
         h_ld[1] <= bus.id_is_load;
         h_rd[1] <= bus.id_rd;
         fwd1_q  <= issue ? sel1 : '0;
         fwd2_q  <= issue ? sel2 : '0;
         if (stall && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.id_stall    = stall;
   assign bus.ex_fwd1_sel = fwd1_q;
   assign bus.ex_fwd2_sel = fwd2_q;
   assign bus.stall_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then random traffic, all checked against a
// cycle-indexed issue log that derives producer distances directly.
module tb_fwd_hazard_unit;
   localparam int DEPTH     = 3;
   localparam int LOAD_DIST = 2;
   localparam int RA_W      = 5;
   localparam int CNT_W     = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;
   localparam int LOG_N     = 4096;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fwd_hazard_if #(.RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

   fwd_hazard_unit #(.DEPTH(DEPTH), .LOAD_DIST(LOAD_DIST), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
   endtask

   // Issue log: what was issued in each cycle, plus the cycle of the last reset edge.
   bit log_v  [LOG_N];
   bit log_we [LOG_N];
   bit log_ld [LOG_N];
   int log_rd [LOG_N];
   int cyc     = 0;
   int rst_cyc = -1;
   int m_sel1 = 0, m_sel2 = 0, m_cnt = 0;
   int w1, w2;
   bit h1, h2, m_stall, m_issue;

   task automatic youngest(input int r, input bit used, output int win, output bit haz);
      win = 0;
      haz = 1'b0;
      for (int d = DEPTH; d >= 1; d--) begin
         int c;
         c = cyc - d;
         if (c > rst_cyc && c >= 0 && log_v[c] && log_we[c] && log_rd[c] == r && r != 0 && used) begin
            win = d;
            haz = log_ld[c] && (d < LOAD_DIST);
         end
      end
   endtask

   task automatic tick();
      #1;
      youngest(int'(bus.id_rs1), bus.id_rs1_used, w1, h1);
      youngest(int'(bus.id_rs2), bus.id_rs2_used, w2, h2);
      m_stall = bus.id_valid && !bus.flush && (h1 || h2);
      m_issue = bus.id_valid && !bus.flush && !m_stall;
      chk("id_stall", longint'(bus.id_stall), longint'(m_stall));
      @(posedge clk);
      if (!rst) begin
         rst_cyc = cyc;
         log_v[cyc] = 1'b0;
         m_sel1 = 0;
         m_sel2 = 0;
         m_cnt  = 0;
      end else begin
         log_v[cyc]  = m_issue;
         log_we[cyc] = bus.id_rd_we && bus.id_rd != 0;
         log_ld[cyc] = bus.id_is_load;
         log_rd[cyc] = int'(bus.id_rd);
         m_sel1 = m_issue ? w1 : 0;
         m_sel2 = m_issue ? w2 : 0;
         if (m_stall && m_cnt < CNT_MAX) m_cnt++;
      end
      cyc++;
      #1;
      chk("ex_fwd1_sel", longint'(bus.ex_fwd1_sel), longint'(m_sel1));
      chk("ex_fwd2_sel", longint'(bus.ex_fwd2_sel), longint'(m_sel2));
      chk("stall_cnt", longint'(bus.stall_cnt), longint'(m_cnt));
      @(negedge clk);
   endtask

   task automatic set_i(input bit vld, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit we, input bit ld, input bit fl);
      bus.id_valid    = vld;
      bus.id_rs1      = RA_W'(rs1);
      bus.id_rs1_used = u1;
      bus.id_rs2      = RA_W'(rs2);
      bus.id_rs2_used = u2;
      bus.id_rd       = RA_W'(rd);
      bus.id_rd_we    = we;
      bus.id_is_load  = ld;
      bus.flush       = fl;
   endtask

   task automatic nop();
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
   endtask

   initial begin
      set_i(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b1;
      chk("rst_sel1", longint'(bus.ex_fwd1_sel), 0);
      chk("rst_cnt", longint'(bus.stall_cnt), 0);

      // addi x5,x0,1 ; add x6,x5,x5
      set_i(1, 0, 1, 0, 0, 5, 1, 0, 0); tick();
      set_i(1, 5, 1, 5, 1, 6, 1, 0, 0); tick();
      chk("alu_fwd1", longint'(bus.ex_fwd1_sel), 1);
      chk("alu_fwd2", longint'(bus.ex_fwd2_sel), 1);

      // lw x7,0(x1) ; add x8,x7,x2 -> one stall cycle, then issue at distance 2
      set_i(1, 1, 1, 0, 0, 7, 1, 1, 0); tick();
      set_i(1, 7, 1, 2, 1, 8, 1, 0, 0); tick();
      chk("lu_cnt", longint'(bus.stall_cnt), 1);
      tick();
      chk("lu_fwd1", longint'(bus.ex_fwd1_sel), 2);
      chk("lu_fwd2", longint'(bus.ex_fwd2_sel), 0);

      // youngest producer wins; distance 3 still forwards; distance 4 reads regfile
      set_i(1, 0, 1, 0, 0, 9, 1, 0, 0); tick(); tick();
      set_i(1, 9, 1, 9, 1, 10, 1, 0, 0); tick();
      chk("young_fwd1", longint'(bus.ex_fwd1_sel), 1);
      set_i(1, 0, 1, 0, 0, 9, 1, 0, 0); tick(); nop(); nop();
      set_i(1, 9, 1, 9, 1, 10, 1, 0, 0); tick();
      chk("dist3_fwd2", longint'(bus.ex_fwd2_sel), 3);
      set_i(1, 0, 1, 0, 0, 9, 1, 0, 0); tick(); nop(); nop(); nop();
      set_i(1, 9, 1, 9, 1, 10, 1, 0, 0); tick();
      chk("dist4_fwd1", longint'(bus.ex_fwd1_sel), 0);

      // lw x3 ; beq x3,x0 flushed in its would-be stall cycle
      set_i(1, 1, 1, 0, 0, 3, 1, 1, 0); tick();
      set_i(1, 3, 1, 0, 1, 0, 0, 0, 1); tick();
      chk("flush_cnt", longint'(bus.stall_cnt), 1);
      nop();

      // x0 writer never forwards; unused sources never match
      set_i(1, 0, 1, 0, 0, 0, 1, 0, 0); tick();
      set_i(1, 0, 1, 0, 1, 1, 1, 0, 0); tick();
      set_i(1, 0, 0, 0, 0, 4, 1, 0, 0); tick();
      set_i(1, 4, 0, 4, 0, 11, 1, 0, 0); tick();
      chk("unused_fwd1", longint'(bus.ex_fwd1_sel), 0);

      // mid-operation reset discards history
      set_i(1, 0, 1, 0, 0, 5, 1, 1, 0); tick();
      rst = 1'b0;
      set_i(1, 0, 1, 0, 0, 5, 1, 0, 0); tick();
      rst = 1'b1;
      set_i(1, 5, 1, 5, 1, 6, 1, 0, 0); tick();
      chk("post_rst_fwd1", longint'(bus.ex_fwd1_sel), 0);
      chk("post_rst_cnt", longint'(bus.stall_cnt), 0);

      // five load-use stalls saturate the 2-bit counter
      repeat (5) begin
         set_i(1, 1, 1, 0, 0, 7, 1, 1, 0); tick();
         set_i(1, 7, 1, 2, 1, 8, 1, 0, 0); tick(); tick();
      end
      chk("sat_cnt", longint'(bus.stall_cnt), CNT_MAX);

      // random traffic on a small register set to provoke matches
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         set_i($urandom_range(0, 4) != 0,
               $urandom_range(0, 3), $urandom_range(0, 5) != 0,
               $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
